// File: rtl/shift_arbiter_8_if.sv
// Request/response bundle between the two shifter clients and shift_arbiter_8.
// Lane i of each packed request field belongs to requester i.
interface shift_arbiter_8_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] req_data;
    logic [1:0]  req_left;
    logic [5:0]  req_amt;
    logic [1:0]  req_rot;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [7:0]  rsp_data;

    modport master (
        output req_valid, req_data, req_left, req_amt, req_rot, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req_valid, req_data, req_left, req_amt, req_rot, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/shift_arbiter_8.sv
// Round-robin front end sharing one 8-bit logical shifter core between two requesters.
// Define SHIFT_ARB_ROTATE_EN to add circular rotate through a second core pass.

module shift_core_8 (
    input  logic [7:0] data,
    input  logic       left,
    input  logic [2:0] amt,
    output logic [7:0] result
);
    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7 - i];
        return r;
    endfunction

    logic [7:0] pre;
    logic [7:0] shifted;

    // Left shifts reuse the right shifter by mirroring the operand around it.
    always_comb begin
        pre     = left ? rev8(data) : data;
        shifted = pre >> amt;
        result  = left ? rev8(shifted) : shifted;
    end
endmodule

module shift_arbiter_8 #(
    parameter int DATA_W = 8,
    parameter int N_REQ  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    shift_arbiter_8_if.slave bus,
    output logic             busy
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS1 = 2'd1,
        RESP  = 2'd2
`ifdef SHIFT_ARB_ROTATE_EN
        , PASS2 = 2'd3
`endif
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [DATA_W-1:0] op_data;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] core_out;
    logic [2:0]        op_amt;
    logic [2:0]        core_amt;
    logic              op_left;
    logic              op_id;
    logic              core_left;
    logic              last_grant;
    logic              grant;
    logic              accept;
    logic [N_REQ-1:0]  grant_vec;
`ifdef SHIFT_ARB_ROTATE_EN
    logic              op_rot;
`else
    logic              unused_rot;
    assign unused_rot = ^bus.req_rot;
`endif

    // A lone requester always wins; a tie goes to whoever was not served last.
    always_comb begin
        if (bus.req_valid == 2'b11) grant = ~last_grant;
        else                        grant = ~bus.req_valid[0];
        grant_vec = grant ? 2'b10 : 2'b01;
        accept    = |(bus.req_valid & bus.req_ready);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (accept) next_state = PASS1;
`ifdef SHIFT_ARB_ROTATE_EN
            PASS1: next_state = op_rot ? PASS2 : RESP;
            PASS2: next_state = RESP;
`else
            PASS1: next_state = RESP;
`endif
            RESP:  if (bus.rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // req_ready is masked by rst_n so nothing looks grantable while reset is held.
    always_comb begin
        bus.req_ready = '0;
        if (state == IDLE && (|bus.req_valid) && rst_n) bus.req_ready = grant_vec;
        bus.rsp_valid = (state == RESP);
        busy          = (state != IDLE);
    end

    always_comb begin
        core_left = op_left;
        core_amt  = op_amt;
`ifdef SHIFT_ARB_ROTATE_EN
        // Second half of a rotate: opposite direction by the complementary amount.
        if (state == PASS2) begin
            core_left = ~op_left;
            core_amt  = 3'd0 - op_amt;
        end
`endif
    end

    shift_core_8 u_core (
        .data   (op_data),
        .left   (core_left),
        .amt    (core_amt),
        .result (core_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_data    <= '0;
            op_left    <= 1'b0;
            op_amt     <= 3'd0;
            op_id      <= 1'b0;
            acc        <= '0;
            last_grant <= 1'b1;
`ifdef SHIFT_ARB_ROTATE_EN
            op_rot     <= 1'b0;
`endif
        end else begin
            if (state == IDLE && accept) begin
                op_data <= grant ? bus.req_data[15:8] : bus.req_data[7:0];
                op_left <= grant ? bus.req_left[1]    : bus.req_left[0];
                op_amt  <= grant ? bus.req_amt[5:3]   : bus.req_amt[2:0];
                op_id   <= grant;
`ifdef SHIFT_ARB_ROTATE_EN
                op_rot  <= grant ? bus.req_rot[1]     : bus.req_rot[0];
`endif
            end
            if (state == PASS1) acc <= core_out;
`ifdef SHIFT_ARB_ROTATE_EN
            if (state == PASS2) acc <= acc | core_out;
`endif
            if (state == RESP && bus.rsp_ready) last_grant <= op_id;
        end
    end

    assign bus.rsp_data = acc;
    assign bus.rsp_id   = op_id;
endmodule

// File: tb/tb_shift_arbiter_8.sv
// Directed bench for shift_arbiter_8: vector table plus reset, fairness and backpressure sequences.
// Rotate expectations switch on SHIFT_ARB_ROTATE_EN.
`timescale 1ns/1ps
module tb_shift_arbiter_8;
    logic clk = 1'b0;
    logic rst_n;
    logic busy;
    int   checks = 0;
    int   errors = 0;

    shift_arbiter_8_if bus ();

    shift_arbiter_8 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

`ifdef SHIFT_ARB_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    typedef struct {
        logic       id;
        logic [7:0] data;
        logic       left;
        logic [2:0] amt;
        logic       rot;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // The idle lane carries inverted operands so a wrong lane select shows up.
    task automatic apply_stimulus(input vec_t v);
        bus.req_data  = v.id ? {v.data, ~v.data} : {~v.data, v.data};
        bus.req_left  = v.id ? {v.left, ~v.left} : {~v.left, v.left};
        bus.req_amt   = v.id ? {v.amt, ~v.amt}   : {~v.amt, v.amt};
        bus.req_rot   = v.id ? {v.rot, 1'b0}     : {1'b0, v.rot};
        bus.req_valid = v.id ? 2'b10 : 2'b01;
    endtask

    task automatic wait_ready(input logic [1:0] sel, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if ((bus.req_ready & sel) != 2'b00) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_ready actual=timeout required=grant");
        end
    endtask

    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus.rsp_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_rsp actual=timeout required=rsp_valid");
        end
    endtask

    task automatic run_vector(input int idx, input vec_t v);
        bit ok;
        int lat;
        apply_stimulus(v);
        wait_ready(v.id ? 2'b10 : 2'b01, ok);
        if (ok) begin
            check_output($sformatf("v%0d_req_ready", idx), 16'(bus.req_ready), v.id ? 16'h2 : 16'h1);
            tick();
            bus.req_valid = 2'b00;
            lat = (v.rot && ROT) ? 3 : 2;
            for (int k = 1; k < lat; k++) begin
                check_output($sformatf("v%0d_rsp_valid_early", idx), 16'(bus.rsp_valid), 16'h0);
                tick();
            end
            check_output($sformatf("v%0d_rsp_valid", idx), 16'(bus.rsp_valid), 16'h1);
            check_output($sformatf("v%0d_rsp_id", idx), 16'(bus.rsp_id), 16'(v.id));
            check_output($sformatf("v%0d_rsp_data", idx), 16'(bus.rsp_data), 16'(v.exp));
            tick();
            check_output($sformatf("v%0d_rsp_valid_drop", idx), 16'(bus.rsp_valid), 16'h0);
            check_output($sformatf("v%0d_busy_idle", idx), 16'(busy), 16'h0);
        end
    endtask

    initial begin
        bit   ok;
        vec_t rv;

        vecs[0] = '{1'b0, 8'hB1, 1'b0, 3'd3, 1'b0, 8'h16};
        vecs[1] = '{1'b1, 8'hB1, 1'b1, 3'd2, 1'b0, 8'hC4};
        vecs[2] = '{1'b1, 8'hB1, 1'b1, 3'd0, 1'b0, 8'hB1};
        vecs[3] = '{1'b0, 8'hFF, 1'b1, 3'd7, 1'b0, 8'h80};
        vecs[4] = '{1'b0, 8'hFF, 1'b0, 3'd7, 1'b0, 8'h01};
        vecs[5] = '{1'b1, 8'hB1, 1'b0, 3'd3, 1'b1, ROT ? 8'h36 : 8'h16};
        vecs[6] = '{1'b0, 8'hB1, 1'b1, 3'd3, 1'b1, ROT ? 8'h8D : 8'h88};
        vecs[7] = '{1'b1, 8'h5A, 1'b1, 3'd0, 1'b1, 8'h5A};

        rst_n         = 1'b0;
        bus.req_valid = 2'b11;
        bus.req_data  = 16'h0;
        bus.req_left  = 2'b00;
        bus.req_amt   = 6'd0;
        bus.req_rot   = 2'b00;
        bus.rsp_ready = 1'b1;
        repeat (3) tick();
        check_output("rst_req_ready", 16'(bus.req_ready), 16'h0);
        check_output("rst_rsp_valid", 16'(bus.rsp_valid), 16'h0);
        check_output("rst_busy", 16'(busy), 16'h0);
        check_output("rst_rsp_data", 16'(bus.rsp_data), 16'h0);
        check_output("rst_rsp_id", 16'(bus.rsp_id), 16'h0);
        rst_n = 1'b1;
        #1;
        check_output("rel_req_ready", 16'(bus.req_ready), 16'h1);
        bus.req_valid = 2'b00;
        tick();
        check_output("withdraw_busy", 16'(busy), 16'h0);

        for (int i = 0; i < 8; i++) run_vector(i, vecs[i]);

        // Both requesters stay valid; the grant must alternate starting with 0.
        bus.req_data  = {8'hF0, 8'h0F};
        bus.req_left  = 2'b01;
        bus.req_amt   = {3'd4, 3'd4};
        bus.req_rot   = 2'b00;
        bus.req_valid = 2'b11;
        for (int n = 0; n < 4; n++) begin
            wait_ready(2'b11, ok);
            if (!ok) break;
            check_output($sformatf("fair%0d_req_ready", n), 16'(bus.req_ready), (n % 2) ? 16'h2 : 16'h1);
            tick();
            wait_rsp(ok);
            if (!ok) break;
            check_output($sformatf("fair%0d_rsp_id", n), 16'(bus.rsp_id), 16'(n % 2));
            check_output($sformatf("fair%0d_rsp_data", n), 16'(bus.rsp_data), (n % 2) ? 16'h0F : 16'hF0);
            tick();
        end
        bus.req_valid = 2'b00;
        tick();

        bus.req_data  = {8'h81, 8'h81};
        bus.req_left  = 2'b10;
        bus.req_amt   = {3'd1, 3'd1};
        bus.rsp_ready = 1'b0;
        bus.req_valid = 2'b01;
        wait_ready(2'b01, ok);
        tick();
        bus.req_valid = 2'b11;
        wait_rsp(ok);
        for (int c = 0; c < 5; c++) begin
            check_output($sformatf("bp%0d_rsp_data", c), 16'(bus.rsp_data), 16'h40);
            check_output($sformatf("bp%0d_rsp_id", c), 16'(bus.rsp_id), 16'h0);
            check_output($sformatf("bp%0d_req_ready", c), 16'(bus.req_ready), 16'h0);
            check_output($sformatf("bp%0d_busy", c), 16'(busy), 16'h1);
            tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        check_output("bp_release_busy", 16'(busy), 16'h0);
        check_output("bp_release_req_ready", 16'(bus.req_ready), 16'h2);
        bus.req_valid = 2'b10;
        tick();
        bus.req_valid = 2'b00;
        wait_rsp(ok);
        check_output("bp_next_rsp_id", 16'(bus.rsp_id), 16'h1);
        check_output("bp_next_rsp_data", 16'(bus.rsp_data), 16'h02);
        tick();

        // Reset lands in the last core pass of an in-flight operation from requester 1.
        rv = '{1'b1, 8'hB1, 1'b0, 3'd3, 1'b1, 8'h00};
        apply_stimulus(rv);
        wait_ready(2'b10, ok);
        tick();
        bus.req_valid = 2'b11;
        if (ROT) tick();
        rst_n = 1'b0;
        #1;
        check_output("midrst_rsp_valid", 16'(bus.rsp_valid), 16'h0);
        check_output("midrst_busy", 16'(busy), 16'h0);
        check_output("midrst_req_ready", 16'(bus.req_ready), 16'h0);
        check_output("midrst_rsp_data", 16'(bus.rsp_data), 16'h0);
        check_output("midrst_rsp_id", 16'(bus.rsp_id), 16'h0);
        repeat (2) tick();
        bus.req_valid = 2'b00;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            check_output($sformatf("postrst%0d_rsp_valid", c), 16'(bus.rsp_valid), 16'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
